zigbee_cordic_pipe: RTL



---
 rtl/zigbee_cordic_pkg.sv | 36 +++
 rtl/zigbee_cordic_pipe_stage.sv | 58 +++++
 rtl/zigbee_cordic_pipe.sv | 106 ++++++++++
 3 files changed

// File: rtl/zigbee_cordic_pkg.sv
// ----------------------------------------------------------------------------
// zigbee_cordic_pkg : shared constants and arctangent LUT for the CORDIC pipe
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package zigbee_cordic_pkg;

  localparam int XY_GUARD = 2;

  // atan(2^-i)/(2*pi) held as a 32-bit turn fraction, then rounded to w_size bits.
  function automatic int cordic_atan(input int i, input int w_size);
    logic [63:0] frac;
    logic [63:0] prod;
    case (i)
      0:       frac = 64'd536870912;
      1:       frac = 64'd316933406;
      2:       frac = 64'd167458907;
      3:       frac = 64'd85004756;
      4:       frac = 64'd42667331;
      5:       frac = 64'd21354465;
      6:       frac = 64'd10679838;
      7:       frac = 64'd5340245;
      8:       frac = 64'd2670163;
      9:       frac = 64'd1335087;
      10:      frac = 64'd667544;
      11:      frac = 64'd333772;
      default: frac = 64'd683565276 >> i;
    endcase
    prod = (frac << w_size) + 64'd2147483648;
    return int'(prod >> 32);
  endfunction

endpackage

`default_nettype wire

// File: rtl/zigbee_cordic_pipe_stage.sv
// ----------------------------------------------------------------------------
// zigbee_cordic_pipe_stage : one registered CORDIC vectoring micro-rotation
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module zigbee_cordic_pipe_stage
  import zigbee_cordic_pkg::*;
#(
  parameter int STAGE_IDX = 0,
  parameter int XY_SIZE   = 7,
  parameter int W_SIZE    = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      i_valid,
  input  logic signed [XY_SIZE-1:0] i_x,
  input  logic signed [XY_SIZE-1:0] i_y,
  input  logic        [W_SIZE-1:0]  i_w,
  output logic                      o_valid,
  output logic signed [XY_SIZE-1:0] o_x,
  output logic signed [XY_SIZE-1:0] o_y,
  output logic        [W_SIZE-1:0]  o_w
);

  localparam logic [W_SIZE-1:0] c_ATAN = W_SIZE'(cordic_atan(STAGE_IDX, W_SIZE));

  logic signed [XY_SIZE-1:0] w_xs;
  logic signed [XY_SIZE-1:0] w_ys;

  assign w_xs = i_x >>> STAGE_IDX;
  assign w_ys = i_y >>> STAGE_IDX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_w     <= '0;
    end else if (en) begin
      o_valid <= i_valid;
      // Rotate toward y=0; the angle accumulator wraps modulo a full turn.
      if (!i_y[XY_SIZE-1]) begin
        o_x <= i_x + w_ys;
        o_y <= i_y - w_xs;
        o_w <= i_w + c_ATAN;
      end else begin
        o_x <= i_x - w_ys;
        o_y <= i_y + w_xs;
        o_w <= i_w - c_ATAN;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/zigbee_cordic_pipe.sv
// ----------------------------------------------------------------------------
// zigbee_cordic_pipe : pipelined CORDIC vectoring (I/Q -> angle, magnitude)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module zigbee_cordic_pipe
  import zigbee_cordic_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int IQ_SIZE    = 5,
  parameter int W_SIZE     = 6,
  parameter int MAG_EN     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [IQ_SIZE-1:0] Ibb,
  input  logic signed [IQ_SIZE-1:0] Qbb,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic        [W_SIZE-1:0]  Wout,
  output logic        [IQ_SIZE+1:0] Mag,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int XY = IQ_SIZE + XY_GUARD;

  logic                 w_en;
  logic signed [XY-1:0] w_iext;
  logic signed [XY-1:0] w_qext;

  logic                 r_v0;
  logic signed [XY-1:0] r_x0;
  logic signed [XY-1:0] r_y0;
  logic [W_SIZE-1:0]    r_w0;

  logic                 w_v [NUM_STAGES+1];
  logic signed [XY-1:0] w_x [NUM_STAGES+1];
  logic signed [XY-1:0] w_y [NUM_STAGES+1];
  logic [W_SIZE-1:0]    w_w [NUM_STAGES+1];

  assign w_en     = out_ready | ~out_valid;
  assign in_ready = w_en;

  // Widen before negating so the most negative input stays representable.
  assign w_iext = {{XY_GUARD{Ibb[IQ_SIZE-1]}}, Ibb};
  assign w_qext = {{XY_GUARD{Qbb[IQ_SIZE-1]}}, Qbb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0 <= 1'b0;
      r_x0 <= '0;
      r_y0 <= '0;
      r_w0 <= '0;
    end else if (w_en) begin
      r_v0 <= in_valid;
      if (Ibb[IQ_SIZE-1]) begin
        r_x0 <= -w_iext;
        r_y0 <= -w_qext;
        r_w0 <= {1'b1, {(W_SIZE-1){1'b0}}};
      end else begin
        r_x0 <= w_iext;
        r_y0 <= w_qext;
        r_w0 <= '0;
      end
    end
  end

  assign w_v[0] = r_v0;
  assign w_x[0] = r_x0;
  assign w_y[0] = r_y0;
  assign w_w[0] = r_w0;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    zigbee_cordic_pipe_stage #(
      .STAGE_IDX (g),
      .XY_SIZE   (XY),
      .W_SIZE    (W_SIZE)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (w_en),
      .i_valid (w_v[g]),
      .i_x     (w_x[g]),
      .i_y     (w_y[g]),
      .i_w     (w_w[g]),
      .o_valid (w_v[g+1]),
      .o_x     (w_x[g+1]),
      .o_y     (w_y[g+1]),
      .o_w     (w_w[g+1])
    );
  end

  assign out_valid = w_v[NUM_STAGES];
  assign Wout      = w_w[NUM_STAGES];

  if (MAG_EN != 0) begin : g_mag
    assign Mag = w_x[NUM_STAGES] & {1'b0, {(XY-1){1'b1}}};
  end else begin : g_nomag
    assign Mag = '0;
  end

endmodule

`default_nettype wire
